pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/pipeline_ctrl_stall_encoder.sv | 28 ++
 rtl/pipeline_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// pipeline stage indices and common control constants.
package pipeline_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MC         = 2'd1,
        ST_FLUSH_WAIT = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    // Stage indices into the stall vector
    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;
    localparam int unsigned NUM_STG = 5;
    localparam int unsigned NUM_REQ = 4;

    localparam int unsigned PC_W = 32;

    // Common control levels
    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Maps per-stage stall requests to a per-stage hold vector: the highest
// active request holds its own stage and every stage in front of it.
// Ports:
//   req      [NUM_REQ-1:0] in  requests, bit index = stage (IF, ID, EX, MEM)
//   hold_off               in  force all holds low (pipeline is flushing)
//   stall    [NUM_STG-1:0] out per-stage hold, WB never held
module pipeline_ctrl_stall_encoder
    import pipeline_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold_off,
    output logic [NUM_STG-1:0] stall
);

    // Thermometer fill from the highest requesting stage down to IF
    always_comb begin
        stall          = '0;
        stall[STG_MEM] = req[STG_MEM];
        stall[STG_EX]  = req[STG_MEM] | req[STG_EX];
        stall[STG_ID]  = req[STG_MEM] | req[STG_EX] | req[STG_ID];
        stall[STG_IF]  = req[STG_MEM] | req[STG_EX] | req[STG_ID] | req[STG_IF];
        stall[STG_WB]  = NO_STOP;
        if (hold_off) begin
            stall = '0;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage stall generation, EX multi-cycle
// sequencing, exception flush with redirect, and an IF-stall watchdog.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if/id/mem_stall_req            stage stall requests
//   mc_start, mc_cycles[MC_W]      launch an EX multi-cycle op of mc_cycles cycles
//   exc_valid, exc_pc[32]          exception from MEM and its handler address
//   stall[5]                       per-stage hold (combinational)
//   flush, flush_pc[32]            one-cycle flush pulse and redirect target
//   mc_busy                        multi-cycle op in progress
//   timeout                        sticky watchdog flag
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MC_W    = 6,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall_req,
    input  logic              id_stall_req,
    input  logic              mem_stall_req,
    input  logic              mc_start,
    input  logic [MC_W-1:0]   mc_cycles,
    input  logic              exc_valid,
    input  logic [PC_W-1:0]   exc_pc,
    output logic [NUM_STG-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   flush_pc,
    output logic              mc_busy,
    output logic              timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t            state, state_d;
    logic [MC_W-1:0]   mc_cnt, mc_cnt_d;
    logic [PC_W-1:0]   flush_pc_d;
    logic [WD_W-1:0]   wd_cnt;

    // EX request comes from the running multi-cycle op; registered holds
    // are masked while rst is asserted so only live requests show.
    pipeline_ctrl_stall_encoder u_stall_encoder (
        .req      ({mem_stall_req, mc_busy & ~rst, id_stall_req, if_stall_req}),
        .hold_off ((state == ST_FLUSH) & ~rst),
        .stall    (stall)
    );

    // Next-state, multi-cycle counter and redirect capture
    always_comb begin
        state_d    = state;
        mc_cnt_d   = mc_cnt;
        flush_pc_d = flush_pc;
        case (state)
            ST_RUN, ST_MC: begin
                if (exc_valid) begin
                    // Exception wins over mc_start and aborts any op in flight
                    flush_pc_d = exc_pc;
                    mc_cnt_d   = '0;
                    state_d    = mem_stall_req ? ST_FLUSH_WAIT : ST_FLUSH;
                end else if (state == ST_RUN) begin
                    if (mc_start && (mc_cycles != '0)) begin
                        mc_cnt_d = mc_cycles;
                        state_d  = ST_MC;
                    end
                end else if (!mem_stall_req) begin
                    // Countdown freezes while MEM holds EX
                    if (mc_cnt == MC_W'(1)) begin
                        mc_cnt_d = '0;
                        state_d  = ST_RUN;
                    end else begin
                        mc_cnt_d = mc_cnt - MC_W'(1);
                    end
                end
            end
            ST_FLUSH_WAIT: begin
                if (!mem_stall_req) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_RUN;
            mc_cnt   <= '0;
            flush_pc <= '0;
            mc_busy  <= 1'b0;
            flush    <= 1'b0;
        end else begin
            state    <= state_d;
            mc_cnt   <= mc_cnt_d;
            flush_pc <= flush_pc_d;
            mc_busy  <= (state_d == ST_MC);
            flush    <= (state_d == ST_FLUSH);
        end
    end

    // Watchdog on consecutive IF holds; saturates, flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (!stall[STG_IF]) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (stall[STG_IF] && (wd_cnt >= WD_W'(TIMEOUT - 1))) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Each cycle's expected outputs are
// pushed to a scoreboard when the stimulus is applied and popped/compared
// when the outputs are sampled on the falling edge.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall_req = 1'b0;
    logic        id_stall_req = 1'b0;
    logic        mem_stall_req = 1'b0;
    logic        mc_start = 1'b0;
    logic [5:0]  mc_cycles = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_pc = '0;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mc_busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       nm;
        logic [4:0]  st;
        logic        busy;
        logic        fl;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc = '0;
    logic        exp_to = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MC_W(6), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .id_stall_req  (id_stall_req),
        .mem_stall_req (mem_stall_req),
        .mc_start      (mc_start),
        .mc_cycles     (mc_cycles),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .mc_busy       (mc_busy),
        .timeout       (timeout)
    );

    // One clock cycle: apply inputs after the edge, push expectations,
    // then pop and compare at the falling edge.
    task automatic cyc(input string nm, input logic r, ifr, idr, memr, mcs,
                       input logic [5:0] mcc, input logic exv, input logic [31:0] expc,
                       input logic [4:0] e_st, input logic e_busy, e_fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; if_stall_req = ifr; id_stall_req = idr; mem_stall_req = memr;
        mc_start = mcs; mc_cycles = mcc; exc_valid = exv; exc_pc = expc;
        e.nm = nm; e.st = e_st; e.busy = e_busy; e.fl = e_fl; e.pc = exp_pc; e.to = exp_to;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (stall !== e.st) begin
            bad++; $display("FAIL %s stall got=%b want=%b", e.nm, stall, e.st);
        end
        total++;
        if (mc_busy !== e.busy) begin
            bad++; $display("FAIL %s mc_busy got=%b want=%b", e.nm, mc_busy, e.busy);
        end
        total++;
        if (flush !== e.fl) begin
            bad++; $display("FAIL %s flush got=%b want=%b", e.nm, flush, e.fl);
        end
        total++;
        if (flush_pc !== e.pc) begin
            bad++; $display("FAIL %s flush_pc got=%h want=%h", e.nm, flush_pc, e.pc);
        end
        total++;
        if (timeout !== e.to) begin
            bad++; $display("FAIL %s timeout got=%b want=%b", e.nm, timeout, e.to);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        exp_pc = '0; exp_to = 1'b0;
        cyc("rst_idle", 1, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        // live request still shows; exception during reset is dropped
        cyc("rst_comb", 1, 0, 1, 0, 0, 0, 1, 32'hFFFF_0000, 5'b00011, 0, 0);
        cyc("rst_exit", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_stall_encode();
        cyc("enc_id",     0, 0, 1, 0, 0, 0, 0, 32'h0, 5'b00011, 0, 0);
        cyc("enc_id_mem", 0, 0, 1, 1, 0, 0, 0, 32'h0, 5'b01111, 0, 0);
        cyc("enc_if",     0, 1, 0, 0, 0, 0, 0, 32'h0, 5'b00001, 0, 0);
        cyc("enc_none",   0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("enc_mem",    0, 0, 0, 1, 0, 0, 0, 32'h0, 5'b01111, 0, 0);
        cyc("enc_if_id",  0, 1, 1, 0, 0, 0, 0, 32'h0, 5'b00011, 0, 0);
        cyc("enc_clear",  0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_mc();
        cyc("mc3_start", 0, 0, 0, 0, 1, 6'd3, 0, 32'h0, 5'b00000, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("mc3_busy", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00111, 1, 0);
        cyc("mc3_done",  0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("mc0_start", 0, 0, 0, 0, 1, 6'd0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("mc0_ignore", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_mc_mem_stall();
        cyc("mcm_start",  0, 0, 0, 0, 1, 6'd4, 0, 32'h0, 5'b00000, 0, 0);
        cyc("mcm_run1",   0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00111, 1, 0);
        cyc("mcm_frz1",   0, 0, 0, 1, 0, 0, 0, 32'h0, 5'b01111, 1, 0);
        cyc("mcm_frz2",   0, 0, 0, 1, 0, 0, 0, 32'h0, 5'b01111, 1, 0);
        // restart attempt while busy must not reload the counter
        cyc("mcm_run2",   0, 0, 0, 0, 1, 6'd9, 0, 32'h0, 5'b00111, 1, 0);
        cyc("mcm_run3",   0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00111, 1, 0);
        cyc("mcm_run4",   0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00111, 1, 0);
        cyc("mcm_done",   0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_exc_wait();
        cyc("exw_raise", 0, 0, 0, 1, 0, 0, 1, 32'h8000_0180, 5'b01111, 0, 0);
        exp_pc = 32'h8000_0180;
        cyc("exw_hold1", 0, 0, 0, 1, 0, 0, 1, 32'h0BAD_0000, 5'b01111, 0, 0);
        cyc("exw_hold2", 0, 0, 0, 1, 0, 0, 0, 32'h0, 5'b01111, 0, 0);
        cyc("exw_hold3", 0, 0, 0, 1, 0, 0, 0, 32'h0, 5'b01111, 0, 0);
        cyc("exw_fall",  0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("exw_flush", 0, 0, 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 1);
        cyc("exw_after", 0, 0, 1, 0, 0, 0, 0, 32'h0, 5'b00011, 0, 0);
        cyc("exw_idle",  0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_exc_in_mc();
        cyc("exm_start", 0, 0, 0, 0, 1, 6'd5, 0, 32'h0, 5'b00000, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("exm_busy", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00111, 1, 0);
        cyc("exm_raise", 0, 0, 0, 0, 0, 0, 1, 32'h1234_5670, 5'b00111, 1, 0);
        exp_pc = 32'h1234_5670;
        cyc("exm_flush", 0, 0, 0, 0, 1, 6'd3, 1, 32'hDEAD_BEEF, 5'b00000, 0, 1);
        cyc("exm_after", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("exm_idle",  0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        // exception and mc_start together: exception wins, op dropped
        cyc("exs_both",  0, 0, 0, 0, 1, 6'd3, 1, 32'h0000_0040, 5'b00000, 0, 0);
        exp_pc = 32'h0000_0040;
        cyc("exs_flush", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 1);
        cyc("exs_after", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_rst_abort();
        cyc("rsa_start", 0, 0, 0, 0, 1, 6'd5, 0, 32'h0, 5'b00000, 0, 0);
        cyc("rsa_busy",  0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00111, 1, 0);
        cyc("rsa_rst",   1, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 1, 0);
        exp_pc = '0;
        cyc("rsa_clear", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("rsf_raise", 0, 0, 0, 1, 0, 0, 1, 32'hAAAA_0000, 5'b01111, 0, 0);
        exp_pc = 32'hAAAA_0000;
        cyc("rsf_rst",   1, 0, 0, 1, 0, 0, 0, 32'h0, 5'b01111, 0, 0);
        exp_pc = '0;
        cyc("rsf_clear", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("rsf_nopls", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    task automatic test_watchdog();
        exp_to = 1'b0;
        for (int i = 0; i < 7; i++)
            cyc("wd_run7", 0, 1, 0, 0, 0, 0, 0, 32'h0, 5'b00001, 0, 0);
        cyc("wd_break", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("wd_run8", 0, 1, 0, 0, 0, 0, 0, 32'h0, 5'b00001, 0, 0);
        exp_to = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("wd_sticky", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        cyc("wd_rst", 1, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
        exp_to = 1'b0;
        cyc("wd_clear", 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0);
    endtask

    initial begin
        test_reset();
        test_stall_encode();
        test_mc();
        test_mc_mem_stall();
        test_exc_wait();
        test_exc_in_mc();
        test_rst_abort();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
